// File: rtl/axis_capture_pkg.sv
// Shared types and default widths for the ADC->DMA capture sequencer.
package axis_capture_pkg;

  localparam int CAP_TDATA_WIDTH = 64;
  localparam int CAP_CNT_WIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } capture_state_t;

endpackage

// File: rtl/axis_capture_sequencer_if.sv
// AXI4-Stream bundle used for both the source and sink sides of the sequencer.
interface axis_capture_sequencer_if
  import axis_capture_pkg::*;
#(
  parameter int TDATA_WIDTH = CAP_TDATA_WIDTH
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic                       tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/trig_edge_detect.sv
// Rising-edge detector for a level trigger already synchronous to aclk.
module trig_edge_detect (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_trig,
  output logic o_rise
);
  logic r_trig_d;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_trig_d <= 1'b0;
    end else begin
      r_trig_d <= i_trig;
    end
  end

  assign o_rise = i_trig & ~r_trig_d;
endmodule

// File: rtl/axis_capture_sequencer.sv
// Armed, counted, multi-record capture gate between the ADC stream and the DMA sink.
module axis_capture_sequencer
  import axis_capture_pkg::*;
#(
  parameter int TDATA_WIDTH = CAP_TDATA_WIDTH,
  parameter int CNT_WIDTH   = CAP_CNT_WIDTH
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [CNT_WIDTH-1:0]   cfg_length,
  input  logic [CNT_WIDTH-1:0]   cfg_records,
  input  logic [CNT_WIDTH-1:0]   cfg_holdoff,
  axis_capture_sequencer_if.slave  s_axis,
  axis_capture_sequencer_if.master m_axis,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   record_idx,
  output logic                   overrun,
  output logic                   aborted
);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  capture_state_t           r_state;
  logic [CNT_WIDTH-1:0]     r_len;
  logic [CNT_WIDTH-1:0]     r_records;
  logic [CNT_WIDTH-1:0]     r_holdoff;
  logic [CNT_WIDTH-1:0]     r_beat_cnt;
  logic [CNT_WIDTH-1:0]     r_hold_cnt;
  logic [CNT_WIDTH-1:0]     r_record_idx;
  logic                     r_done;
  logic                     r_overrun;
  logic                     r_aborted;

  logic                     w_trig_rise;
  logic                     w_capture;
  logic                     w_last_beat;
  logic                     w_handshake;
  logic [CNT_WIDTH-1:0]     w_next_idx;
  logic [TDATA_WIDTH-1:0]   w_data;
  logic [TDATA_WIDTH/8-1:0] w_keep;
  logic                     w_unused_tlast;

  trig_edge_detect u_trig_edge (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_trig  (trig),
    .o_rise  (w_trig_rise)
  );

  // Gate decode comes only from registered state; data itself is a straight wire.
  assign w_capture   = (r_state == ST_CAPTURE);
  assign w_last_beat = (r_beat_cnt == (r_len - CNT_ONE));
  assign w_handshake = w_capture & s_axis.tvalid & m_axis.tready;
  assign w_next_idx  = r_record_idx + CNT_ONE;

  assign w_data         = s_axis.tdata;
  assign w_keep         = s_axis.tkeep;
  assign w_unused_tlast = s_axis.tlast;

  assign m_axis.tdata  = w_data;
  assign m_axis.tkeep  = w_keep;
  assign m_axis.tvalid = w_capture & s_axis.tvalid;
  assign m_axis.tlast  = w_capture & w_last_beat;
  assign s_axis.tready = w_capture ? m_axis.tready : 1'b1;

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign record_idx = r_record_idx;
  assign overrun    = r_overrun;
  assign aborted    = r_aborted;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_len        <= CNT_ZERO;
      r_records    <= CNT_ZERO;
      r_holdoff    <= CNT_ZERO;
      r_beat_cnt   <= CNT_ZERO;
      r_hold_cnt   <= CNT_ZERO;
      r_record_idx <= CNT_ZERO;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort outranks everything, including a same-cycle arm.
      if (abort) begin
        if (r_state != ST_IDLE) begin
          r_aborted <= 1'b1;
        end
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (arm && (cfg_length != CNT_ZERO) && (cfg_records != CNT_ZERO)) begin
              r_len        <= cfg_length;
              r_records    <= cfg_records;
              r_holdoff    <= cfg_holdoff;
              r_record_idx <= CNT_ZERO;
              r_overrun    <= 1'b0;
              r_aborted    <= 1'b0;
              r_state      <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (w_trig_rise) begin
              r_beat_cnt <= CNT_ZERO;
              r_state    <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (s_axis.tvalid && !m_axis.tready) begin
              r_overrun <= 1'b1;
            end
            if (w_handshake) begin
              r_beat_cnt <= r_beat_cnt + CNT_ONE;
              if (w_last_beat) begin
                if (w_next_idx == r_records) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
                end else begin
                  r_record_idx <= w_next_idx;
                  r_hold_cnt   <= CNT_ZERO;
                  r_state      <= (r_holdoff == CNT_ZERO) ? ST_ARMED : ST_HOLDOFF;
                end
              end
            end
          end
          ST_HOLDOFF: begin
            if (r_hold_cnt == (r_holdoff - CNT_ONE)) begin
              r_state <= ST_ARMED;
            end else begin
              r_hold_cnt <= r_hold_cnt + CNT_ONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_capture_sequencer.sv
// Directed self-checking bench for axis_capture_sequencer.
module tb_axis_capture_sequencer;
  logic        aclk;
  logic        aresetn;
  logic        arm;
  logic        abort;
  logic        trig;
  logic [31:0] cfg_length;
  logic [31:0] cfg_records;
  logic [31:0] cfg_holdoff;
  logic        busy;
  logic        done;
  logic [31:0] record_idx;
  logic        overrun;
  logic        aborted;

  axis_capture_sequencer_if #(.TDATA_WIDTH(64)) s_if ();
  axis_capture_sequencer_if #(.TDATA_WIDTH(64)) m_if ();

  axis_capture_sequencer #(.TDATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .arm         (arm),
    .abort       (abort),
    .trig        (trig),
    .cfg_length  (cfg_length),
    .cfg_records (cfg_records),
    .cfg_holdoff (cfg_holdoff),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .busy        (busy),
    .done        (done),
    .record_idx  (record_idx),
    .overrun     (overrun),
    .aborted     (aborted)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          n_beats;
  int          n_tlast;
  int          n_done;
  int          n_stall;
  int          first_cyc;
  int          last_cyc;
  int          done_cyc;
  int          last_at;
  int          prev_hs;
  int          min_gap;
  int          trig_ph;
  logic [63:0] first_data;
  logic [63:0] last_data;
  logic [31:0] max_idx;
  logic [11:0] idx_trace;
  bit          rdy_tog;
  bit          trig_tog;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; n_beats = 0; n_tlast = 0; n_done = 0; n_stall = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; last_at = -1;
    prev_hs = -1; min_gap = 1000; trig_ph = 0;
    first_data = 64'd0; last_data = 64'd0; max_idx = 32'd0; idx_trace = 12'd0;
  endtask

  // Sample the current cycle (inputs already set by caller), then advance one clock.
  task automatic step();
    bit src_adv;
    #1;
    if (m_if.tvalid && m_if.tready) begin
      n_beats++;
      check_val("pass_data", m_if.tdata, s_if.tdata);
      check_val("pass_keep", {56'd0, m_if.tkeep}, {56'd0, s_if.tkeep});
      if (n_beats == 1) begin
        first_cyc  = cyc;
        first_data = m_if.tdata;
      end
      last_data = m_if.tdata;
      if (prev_hs >= 0 && (cyc - prev_hs - 1) > 0 && (cyc - prev_hs - 1) < min_gap)
        min_gap = cyc - prev_hs - 1;
      prev_hs = cyc;
      if (m_if.tlast) begin
        n_tlast++;
        last_at   = n_beats;
        last_cyc  = cyc;
        idx_trace = {idx_trace[7:0], record_idx[3:0]};
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (s_if.tvalid && !s_if.tready) n_stall++;
    if (record_idx > max_idx) max_idx = record_idx;
    src_adv = s_if.tvalid && s_if.tready;
    @(posedge aclk);
    #1;
    if (src_adv) s_if.tdata = s_if.tdata + 64'd1;
    if (rdy_tog) m_if.tready = ~m_if.tready;
    if (trig_tog) begin
      trig_ph++;
      if (trig_ph == 2) begin
        trig    = ~trig;
        trig_ph = 0;
      end
    end
    cyc++;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    aresetn = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    cfg_length = 32'd0; cfg_records = 32'd0; cfg_holdoff = 32'd0;
    s_if.tvalid = 1'b1; s_if.tdata = 64'h1000; s_if.tkeep = 8'hA5; s_if.tlast = 1'b1;
    m_if.tready = 1'b1;
    rdy_tog = 1'b0; trig_tog = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_busy",     {63'd0, busy},        64'd0);
    check_val("rst_done",     {63'd0, done},        64'd0);
    check_val("rst_idx",      {32'd0, record_idx},  64'd0);
    check_val("rst_overrun",  {63'd0, overrun},     64'd0);
    check_val("rst_aborted",  {63'd0, aborted},     64'd0);
    check_val("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    check_val("rst_m_tlast",  {63'd0, m_if.tlast},  64'd0);
    check_val("rst_s_tready", {63'd0, s_if.tready}, 64'd1);
    aresetn = 1'b1;

    // Test 1: single record of 4, arm at 5, edge at 10
    cfg_length = 32'd4; cfg_records = 32'd1; cfg_holdoff = 32'd0;
    clear_stats();
    for (int c = 0; c < 20; c++) begin
      arm  = (c == 5);
      trig = (c >= 10);
      step();
    end
    arm = 1'b0;
    check_val("t1_beats",     64'(n_beats),   64'd4);
    check_val("t1_first_cyc", 64'(first_cyc), 64'd11);
    check_val("t1_tlast_cyc", 64'(last_cyc),  64'd14);
    check_val("t1_n_tlast",   64'(n_tlast),   64'd1);
    check_val("t1_done_cyc",  64'(done_cyc),  64'd15);
    check_val("t1_n_done",    64'(n_done),    64'd1);
    check_val("t1_stalls",    64'(n_stall),   64'd0);
    check_val("t1_busy",      {63'd0, busy},  64'd0);
    check_val("t1_overrun",   {63'd0, overrun}, 64'd0);

    // Test 2: 3 records of 3, holdoff 5, trig toggling every 2 cycles
    trig = 1'b0; step();
    cfg_length = 32'd3; cfg_records = 32'd3; cfg_holdoff = 32'd5;
    clear_stats();
    trig_tog = 1'b1;
    for (int c = 0; c < 80; c++) begin
      arm = (c == 0);
      step();
    end
    arm = 1'b0; trig_tog = 1'b0; trig = 1'b0;
    check_val("t2_beats",     64'(n_beats),  64'd9);
    check_val("t2_n_tlast",   64'(n_tlast),  64'd3);
    check_val("t2_n_done",    64'(n_done),   64'd1);
    check_val("t2_idx_trace", {52'd0, idx_trace}, 64'h012);
    check_val("t2_final_idx", {32'd0, record_idx}, 64'd2);
    check_val("t2_gap_ge6",   64'(min_gap >= 6 && min_gap < 1000), 64'd1);
    check_val("t2_busy",      {63'd0, busy}, 64'd0);

    // Test 3: 8 beats with sink ready toggling every cycle
    step();
    cfg_length = 32'd8; cfg_records = 32'd1; cfg_holdoff = 32'd0;
    clear_stats();
    rdy_tog = 1'b1;
    for (int c = 0; c < 30; c++) begin
      arm  = (c == 1);
      trig = (c >= 4);
      step();
    end
    arm = 1'b0; rdy_tog = 1'b0; m_if.tready = 1'b1; trig = 1'b0;
    check_val("t3_beats",    64'(n_beats), 64'd8);
    check_val("t3_n_tlast",  64'(n_tlast), 64'd1);
    check_val("t3_last_at",  64'(last_at), 64'd8);
    check_val("t3_in_order", last_data - first_data, 64'd7);
    check_val("t3_overrun",  {63'd0, overrun}, 64'd1);
    check_val("t3_n_done",   64'(n_done), 64'd1);

    // Test 4: abort during beat 2 of a 10-beat record
    step();
    cfg_length = 32'd10; cfg_records = 32'd1; cfg_holdoff = 32'd0;
    clear_stats();
    for (int c = 0; c < 15; c++) begin
      arm   = (c == 1);
      trig  = (c >= 4);
      abort = (c == 6);
      step();
    end
    arm = 1'b0; abort = 1'b0; trig = 1'b0;
    check_val("t4_beats",   64'(n_beats), 64'd2);
    check_val("t4_n_tlast", 64'(n_tlast), 64'd0);
    check_val("t4_n_done",  64'(n_done),  64'd0);
    check_val("t4_aborted", {63'd0, aborted}, 64'd1);
    check_val("t4_busy",    {63'd0, busy}, 64'd0);
    arm = 1'b1; step(); arm = 1'b0;
    check_val("t4_rearm_aborted", {63'd0, aborted}, 64'd0);
    check_val("t4_rearm_busy",    {63'd0, busy},    64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    check_val("t4_abort2_aborted", {63'd0, aborted}, 64'd1);
    check_val("t4_abort2_busy",    {63'd0, busy},    64'd0);

    // Test 5: zero-length arm ignored; arm+abort together stays idle
    cfg_length = 32'd0; cfg_records = 32'd2;
    arm = 1'b1; step(); arm = 1'b0;
    check_val("t5_len0_busy",    {63'd0, busy},    64'd0);
    check_val("t5_len0_aborted", {63'd0, aborted}, 64'd1);
    cfg_length = 32'd4; cfg_records = 32'd0;
    arm = 1'b1; step(); arm = 1'b0;
    check_val("t5_rec0_busy", {63'd0, busy}, 64'd0);
    cfg_records = 32'd1;
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    check_val("t5_arm_abort_busy", {63'd0, busy}, 64'd0);

    // Test 6: rising edge coincident with arm is ignored
    cfg_length = 32'd2; cfg_records = 32'd1; cfg_holdoff = 32'd0;
    clear_stats();
    for (int c = 0; c < 16; c++) begin
      arm  = (c == 2);
      trig = ((c >= 2) && (c <= 5)) || (c >= 8);
      if (c == 7) begin
        check_val("t6_still_armed", {63'd0, busy}, 64'd1);
        check_val("t6_no_beats", 64'(n_beats), 64'd0);
      end
      step();
    end
    arm = 1'b0; trig = 1'b0;
    check_val("t6_first_cyc", 64'(first_cyc), 64'd9);
    check_val("t6_beats",     64'(n_beats),   64'd2);
    check_val("t6_n_done",    64'(n_done),    64'd1);

    // Test 7: reset in the middle of a capture
    step();
    cfg_length = 32'd6; cfg_records = 32'd1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); step();
    #1;
    check_val("t7_capturing", {63'd0, m_if.tvalid}, 64'd1);
    aresetn = 1'b0; step(); aresetn = 1'b1;
    #1;
    check_val("t7_rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    check_val("t7_rst_m_tlast",  {63'd0, m_if.tlast},  64'd0);
    check_val("t7_rst_s_tready", {63'd0, s_if.tready}, 64'd1);
    check_val("t7_rst_busy",     {63'd0, busy},        64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_capture_sequencer.md
# axis_capture_sequencer

Sequencing controller for the ADC→DMA capture path: replaces a free-running trigger gate with an armed, counted, multi-record capture engine. After a software arm it waits for a trigger rising edge and passes exactly `cfg_length` AXI4-Stream beats, marking the last beat with `tlast`. It repeats for `cfg_records` records, separated by a programmable holdoff, then returns to idle. Outside capture windows the ADC stream is discarded, never back-pressured.

## Interface
- `TDATA_WIDTH`, 64, stream data width.
- `CNT_WIDTH`, 32, width of the length, record and holdoff counters.
- `aclk` in 1, clock.
- `aresetn` in 1, reset, synchronous, active-low; clock `aclk`.
- `arm` in 1, single-cycle start request; configuration is latched on it.
- `abort` in 1, single-cycle stop request from any state.
- `trig` in 1, trigger level, synchronous to `aclk`.
- `cfg_length` in CNT_WIDTH, beats per record.
- `cfg_records` in CNT_WIDTH, records per arm.
- `cfg_holdoff` in CNT_WIDTH, idle cycles between records.
- `s_axis_tvalid`/`tready`/`tdata`/`tkeep`/`tlast` in/out/in/in/in, 1/1/TDATA_WIDTH/TDATA_WIDTH/8/1, source stream; input `tlast` is ignored.
- `m_axis_tvalid`/`tready`/`tdata`/`tkeep`/`tlast` out/in/out/out/out, same widths, sink stream.
- `busy` out 1, state ≠ IDLE.
- `done` out 1, one-cycle pulse when the final record completes.
- `record_idx` out CNT_WIDTH, index of the current record; holds the final count after `done`.
- `overrun` out 1, sticky flag: source valid while sink not ready during CAPTURE. Cleared on accepted arm.
- `aborted` out 1, sticky flag set by abort in any non-IDLE state. Cleared on accepted arm.

## Operation
- States: IDLE, ARMED, CAPTURE, HOLDOFF.
- IDLE:
  - Arm with `cfg_length`≠0 and `cfg_records`≠0 latches all three cfg values, clears `record_idx`, `overrun` and `aborted`, and moves to ARMED.
  - Arm with either value zero is ignored.
  - Arm outside IDLE is ignored.
- Trigger edge: `trig & ~trig_d`, where `trig_d` is registered every cycle in all states.
  - In ARMED an edge moves to CAPTURE and clears `beat_cnt`.
  - Edges in any other state are ignored, not queued.
- CAPTURE, per beat:
  - `m_tvalid = s_tvalid`, `s_tready = m_tready`; data and keep pass through.
  - `m_tlast = (beat_cnt == len-1)`.
  - Each handshake increments `beat_cnt`.
  - On the last-beat handshake: if `record_idx+1 == records`, go to IDLE and pulse `done`. Otherwise increment `record_idx` and go to HOLDOFF, or straight to ARMED if holdoff is 0.
- HOLDOFF: count `holdoff` cycles, then go to ARMED.
- Outside CAPTURE: `s_tready=1`, `m_tvalid=0`, `m_tlast=0`. Source beats are dropped.
- Abort:
  - Highest priority: goes to IDLE next cycle and sets `aborted` if not already in IDLE.
  - A record in flight is truncated with no `tlast`.
  - No `done` pulse.
  - Abort and arm in the same cycle: abort wins.
- Counter widths are unsigned CNT_WIDTH with no wrap. `records` of 2^CNT_WIDTH−1 is legal.

## Timing
- Reset values:
  - State IDLE.
  - `trig_d`, `busy`, `done`, `overrun`, `aborted`, `m_tvalid`, `m_tlast` all 0.
  - `record_idx` 0.
  - `s_tready` 1.
- Arm at cycle N: ARMED at N+1. An edge at N+1 is accepted; an edge at N is not.
- Edge sampled at cycle N in ARMED: CAPTURE at N+1, so the first beat can transfer at N+1. Gate latency is one cycle.
- Datapath is combinational in CAPTURE with zero added latency. All control signals are decoded from registered state.
- `done` is asserted in the cycle after the final handshake, coincident with state becoming IDLE.
- Holdoff of H: H full cycles in HOLDOFF between the last beat and ARMED.
- Reset mid-capture: immediate return to IDLE with reset values, no `tlast`.

## Structure
- Shared package `axis_capture_pkg`:
  - state enum `capture_state_t` (IDLE/ARMED/CAPTURE/HOLDOFF), 2-bit encoding.
  - default CNT_WIDTH constant.
- One sub-module, `trig_edge_detect`, holding the registered `trig_d` and producing a rise pulse; it is reusable across examples.
- The main module holds the FSM, three counters (beat, record, holdoff) and the sticky flags.

## Test plan
- length=4, records=1, continuous valid, ready=1, trig edge at cycle 10 → exactly 4 beats on m_axis at cycles 11–14, tlast at 14, `done` at 15, source never stalled.
- length=3, records=3, holdoff=5, trig held toggling every 2 cycles → 3 records of 3 beats each, ≥5 idle cycles between them, `record_idx` 0→1→2, single `done`.
- length=8, sink ready toggling 1/0 during capture → 8 beats delivered in order, `overrun`=1, tlast only on the 8th.
- abort after beat 2 of length=10 → no further m_tvalid, no tlast, `aborted`=1, `done`=0; next arm clears `aborted`.
- arm with length=0 → state stays IDLE, `busy`=0. Arm and abort in the same cycle → IDLE.
- trig rising in the same cycle as arm → ignored; next rising edge starts capture.
